// File: rtl/npc_pkg.sv
// Shared encodings and helpers for the next-PC / return-address-stack unit.
// npc_sel decodes into a small control struct so the datapath never re-decodes raw codes.
package npc_pkg;

  localparam logic [2:0] NPC_SEQ  = 3'b000;
  localparam logic [2:0] NPC_J    = 3'b001;
  localparam logic [2:0] NPC_BR   = 3'b010;
  localparam logic [2:0] NPC_JR   = 3'b011;
  localparam logic [2:0] NPC_JAL  = 3'b100;
  localparam logic [2:0] NPC_JALR = 3'b101;
  localparam logic [2:0] NPC_RET  = 3'b110;
  localparam logic [2:0] NPC_RSV  = 3'b111;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

  typedef enum logic [1:0] {
    SRC_PC4,
    SRC_JUMP,
    SRC_BR,
    SRC_REG
  } npc_src_e;

  typedef struct packed {
    npc_src_e src;
    logic     push;
    logic     pop;
  } npc_ctrl_t;

  function automatic npc_ctrl_t decode_npc_sel(input logic [2:0] sel);
    npc_ctrl_t c;
    c = '{src: SRC_PC4, push: 1'b0, pop: 1'b0};
    unique case (sel)
      NPC_SEQ:  c.src = SRC_PC4;
      NPC_J:    c.src = SRC_JUMP;
      NPC_BR:   c.src = SRC_BR;
      NPC_JR:   c.src = SRC_REG;
      NPC_JAL:  begin c.src = SRC_JUMP; c.push = 1'b1; end
      NPC_JALR: begin c.src = SRC_REG;  c.push = 1'b1; end
      NPC_RET:  begin c.src = SRC_REG;  c.pop  = 1'b1; end
      NPC_RSV:  c.src = SRC_PC4;
    endcase
    return c;
  endfunction

  // Word offset, sign-extended (the previous unit zero-extended it).
  function automatic logic [31:0] br_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [25:0] addr26);
    return {pc4[31:28], addr26, 2'b00};
  endfunction

endpackage

// File: rtl/npc_ras.sv
// Circular return-address stack: a full push overwrites the oldest entry,
// a pop on an empty stack leaves pointer and count untouched.
module npc_ras #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [31:0]              push_data,
  output logic [31:0]              top,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   entry [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] top_idx;

  assign top_idx = ptr - 1'b1;
  assign valid   = (count != '0);
  assign top     = valid ? entry[top_idx] : 32'h0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset here is synchronous and wins over push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + 1'b1;
      if (count != CW'(DEPTH)) count <= count + 1'b1;
    end else if (pop && valid) begin
      ptr   <= ptr - 1'b1;
      count <= count - 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; count gates every read,
  // so stale entries are never visible and the array can map to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push && !reset) entry[ptr] <= push_data;
  end

endmodule

// File: rtl/npc_ras_unit.sv
// PC register, next-PC selection and RET misprediction counter around npc_ras.
// The RAS only predicts: RET always takes rs_val as its next PC.
module npc_ras_unit
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF,
  parameter int          RAS_DEPTH = 4,
  parameter int          CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       exc_redirect,
  input  logic [2:0]                 npc_sel,
  input  logic                       br_taken,
  input  logic [15:0]                imm16,
  input  logic [25:0]                addr26,
  input  logic [31:0]                rs_val,
  output logic [31:0]                pc,
  output logic [31:0]                npc,
  output logic [31:0]                link_addr,
  output logic [31:0]                ras_top,
  output logic                       ras_valid,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic [CNT_W-1:0]           ras_miss_cnt
);

  npc_ctrl_t   ctrl;
  logic [31:0] pc4;
  logic        advance;
  logic        ras_push;
  logic        ras_pop;
  logic        ret_miss;

  assign ctrl      = decode_npc_sel(npc_sel);
  assign pc4       = pc + 32'd4;
  assign link_addr = pc4;

  // NOTE: npc gets a default before the branches so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    npc = pc4;
    if (exc_redirect) begin
      npc = EXC_VEC;
    end else begin
      unique case (ctrl.src)
        SRC_PC4:  npc = pc4;
        SRC_JUMP: npc = jump_target(pc4, addr26);
        SRC_BR:   npc = br_taken ? pc4 + br_offset(imm16) : pc4;
        SRC_REG:  npc = rs_val;
        default:  npc = pc4;
      endcase
    end
  end

  // An exception redirect suppresses any RAS action the same cycle.
  assign advance  = !stall && !exc_redirect;
  assign ras_push = advance && ctrl.push;
  assign ras_pop  = advance && ctrl.pop;
  assign ret_miss = ras_pop && (!ras_valid || (ras_top != rs_val));

  npc_ras #(
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (link_addr),
    .top       (ras_top),
    .valid     (ras_valid),
    .count     (ras_count)
  );

  always_ff @(posedge clk) begin
    if (reset)       pc <= RESET_PC;
    else if (!stall) pc <= npc;
  end

  always_ff @(posedge clk) begin
    if (reset)
      ras_miss_cnt <= '0;
    else if (ret_miss && (ras_miss_cnt != {CNT_W{1'b1}}))
      ras_miss_cnt <= ras_miss_cnt + 1'b1;
  end

endmodule

// File: tb/tb_npc_ras_unit.sv
// Self-checking bench for npc_ras_unit: directed scenarios plus a randomized run
// against a queue-based reference of the PC / return-address-stack behaviour.
module tb_npc_ras_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC    = 32'h0000_4180;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        exc_redirect;
  logic [2:0]  npc_sel;
  logic        br_taken;
  logic [15:0] imm16;
  logic [25:0] addr26;
  logic [31:0] rs_val;
  logic [31:0] pc;
  logic [31:0] npc;
  logic [31:0] link_addr;
  logic [31:0] ras_top;
  logic        ras_valid;
  logic [2:0]  ras_count;
  logic [15:0] ras_miss_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  int          m_miss;

  npc_ras_unit #(
    .RESET_PC  (RST_PC),
    .EXC_VEC   (EXC),
    .RAS_DEPTH (DEPTH),
    .CNT_W     (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .exc_redirect (exc_redirect),
    .npc_sel      (npc_sel),
    .br_taken     (br_taken),
    .imm16        (imm16),
    .addr26       (addr26),
    .rs_val       (rs_val),
    .pc           (pc),
    .npc          (npc),
    .link_addr    (link_addr),
    .ras_top      (ras_top),
    .ras_valid    (ras_valid),
    .ras_count    (ras_count),
    .ras_miss_cnt (ras_miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_npc();
    logic [31:0] p4;
    int          off;
    p4 = m_pc + 32'd4;
    if (exc_redirect) return EXC;
    case (npc_sel)
      3'd0:       return p4;
      3'd1, 3'd4: return {p4[31:28], addr26, 2'b00};
      3'd2: begin
        off = int'($signed(imm16));
        return br_taken ? p4 + 32'(off * 4) : p4;
      end
      3'd3, 3'd5, 3'd6: return rs_val;
      default:    return p4;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] nxt;
    logic [31:0] popped;
    nxt = model_npc();
    if (reset) begin
      m_pc = RST_PC;
      m_ras.delete();
      m_miss = 0;
    end else if (!stall) begin
      if (!exc_redirect) begin
        if (npc_sel == 3'd4 || npc_sel == 3'd5) begin
          m_ras.push_back(m_pc + 32'd4);
          if (m_ras.size() > DEPTH) popped = m_ras.pop_front();
        end else if (npc_sel == 3'd6) begin
          if (m_ras.size() == 0) begin
            if (m_miss < 65535) m_miss++;
          end else begin
            popped = m_ras.pop_back();
            if (popped != rs_val && m_miss < 65535) m_miss++;
          end
        end
      end
      m_pc = nxt;
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; stall = 1'b0; exc_redirect = 1'b0; npc_sel = 3'd0;
    br_taken = 1'b0; imm16 = '0; addr26 = '0; rs_val = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (pc !== 32'h3000) begin n_bad++; $display("FAIL reset_pc: got %h want %h", pc, 32'h3000); end
    n_cmp++; if (ras_count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", ras_count); end
    n_cmp++; if (ras_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", ras_valid); end
    n_cmp++; if (ras_top !== 32'h0) begin n_bad++; $display("FAIL reset_top: got %h want 0", ras_top); end
    n_cmp++; if (ras_miss_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_miss: got %h want 0", ras_miss_cnt); end
  endtask

  task automatic test_seq();
    logic [31:0] exp_pc;
    exp_pc = 32'h3000;
    npc_sel = 3'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_pc = exp_pc + 32'd4;
      n_cmp++; if (pc !== exp_pc) begin n_bad++; $display("FAIL seq_pc%0d: got %h want %h", i, pc, exp_pc); end
    end
    n_cmp++; if (link_addr !== 32'h3010) begin n_bad++; $display("FAIL seq_link: got %h want %h", link_addr, 32'h3010); end
    n_cmp++; if (ras_count !== 3'd0) begin n_bad++; $display("FAIL seq_count: got %0d want 0", ras_count); end
  endtask

  task automatic test_branch();
    tick();
    n_cmp++; if (pc !== 32'h3010) begin n_bad++; $display("FAIL br_start_pc: got %h want %h", pc, 32'h3010); end
    npc_sel = 3'd2; imm16 = 16'hFFFE; br_taken = 1'b1; #1;
    n_cmp++; if (npc !== 32'h300C) begin n_bad++; $display("FAIL br_back: got %h want %h", npc, 32'h300C); end
    br_taken = 1'b0; #1;
    n_cmp++; if (npc !== 32'h3014) begin n_bad++; $display("FAIL br_not_taken: got %h want %h", npc, 32'h3014); end
    imm16 = 16'h0004; br_taken = 1'b1; #1;
    n_cmp++; if (npc !== 32'h3024) begin n_bad++; $display("FAIL br_fwd: got %h want %h", npc, 32'h3024); end
    tick();
    n_cmp++; if (pc !== 32'h3024) begin n_bad++; $display("FAIL br_pc: got %h want %h", pc, 32'h3024); end
    idle_inputs();
  endtask

  task automatic test_wrap();
    npc_sel = 3'd3; rs_val = 32'hFFFF_FFFC;
    tick();
    n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_jr: got %h want %h", pc, 32'hFFFF_FFFC); end
    npc_sel = 3'd0; #1;
    n_cmp++; if (npc !== 32'h0) begin n_bad++; $display("FAIL wrap_npc: got %h want 0", npc); end
    npc_sel = 3'd7; #1;
    n_cmp++; if (npc !== 32'h0) begin n_bad++; $display("FAIL rsv_npc: got %h want 0", npc); end
    tick();
    n_cmp++; if (pc !== 32'h0 || ras_count !== 3'd0) begin n_bad++; $display("FAIL rsv_step: got pc %h cnt %0d want 0 0", pc, ras_count); end
    idle_inputs();
  endtask

  task automatic test_call_ret();
    do_reset();
    npc_sel = 3'd4; addr26 = 26'h0000C40; #1;
    n_cmp++; if (npc !== 32'h0000_3100) begin n_bad++; $display("FAIL jal_npc: got %h want %h", npc, 32'h3100); end
    tick();
    n_cmp++; if (pc !== 32'h3100) begin n_bad++; $display("FAIL jal_pc: got %h want %h", pc, 32'h3100); end
    n_cmp++; if (ras_top !== 32'h3004 || ras_count !== 3'd1) begin n_bad++; $display("FAIL jal_ras: got top %h cnt %0d want 3004 1", ras_top, ras_count); end
    npc_sel = 3'd6; rs_val = 32'h3004;
    tick();
    n_cmp++; if (pc !== 32'h3004) begin n_bad++; $display("FAIL ret_pc: got %h want %h", pc, 32'h3004); end
    n_cmp++; if (ras_miss_cnt !== 16'd0 || ras_count !== 3'd0) begin n_bad++; $display("FAIL ret_state: got miss %0d cnt %0d want 0 0", ras_miss_cnt, ras_count); end
    idle_inputs();
  endtask

  task automatic test_ras_overflow();
    logic [31:0] link [5];
    logic [31:0] exp_pc;
    do_reset();
    exp_pc = RST_PC;
    for (int i = 0; i < 5; i++) begin
      npc_sel = 3'd4;
      addr26  = 26'h1000 + 26'(i * 4);
      link[i] = exp_pc + 32'd4;
      exp_pc  = {link[i][31:28], addr26, 2'b00};
      tick();
      n_cmp++; if (pc !== exp_pc) begin n_bad++; $display("FAIL ovf_jal%0d: got %h want %h", i, pc, exp_pc); end
    end
    n_cmp++; if (ras_count !== 3'd4) begin n_bad++; $display("FAIL ovf_count: got %0d want 4", ras_count); end
    for (int i = 4; i >= 1; i--) begin
      n_cmp++; if (ras_top !== link[i]) begin n_bad++; $display("FAIL ovf_top%0d: got %h want %h", i, ras_top, link[i]); end
      npc_sel = 3'd6; rs_val = link[i];
      tick();
      n_cmp++; if (pc !== link[i]) begin n_bad++; $display("FAIL ovf_ret%0d: got %h want %h", i, pc, link[i]); end
    end
    n_cmp++; if (ras_miss_cnt !== 16'd0 || ras_count !== 3'd0 || ras_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_drain: got miss %0d cnt %0d valid %b want 0 0 0", ras_miss_cnt, ras_count, ras_valid); end
    rs_val = link[0];
    tick();
    n_cmp++; if (ras_miss_cnt !== 16'd1 || ras_count !== 3'd0) begin n_bad++; $display("FAIL ovf_empty_ret: got miss %0d cnt %0d want 1 0", ras_miss_cnt, ras_count); end
    n_cmp++; if (pc !== link[0]) begin n_bad++; $display("FAIL ovf_empty_pc: got %h want %h", pc, link[0]); end
    idle_inputs();
  endtask

  task automatic test_stall_exc();
    do_reset();
    npc_sel = 3'd4; addr26 = 26'h0000C40; stall = 1'b1;
    tick();
    n_cmp++; if (pc !== 32'h3000 || ras_count !== 3'd0) begin n_bad++; $display("FAIL stall_hold: got pc %h cnt %0d want 3000 0", pc, ras_count); end
    n_cmp++; if (npc !== 32'h3100) begin n_bad++; $display("FAIL stall_npc: got %h want %h", npc, 32'h3100); end
    stall = 1'b0;
    tick();
    n_cmp++; if (pc !== 32'h3100 || ras_count !== 3'd1) begin n_bad++; $display("FAIL stall_release: got pc %h cnt %0d want 3100 1", pc, ras_count); end
    npc_sel = 3'd6; rs_val = 32'h0; exc_redirect = 1'b1; #1;
    n_cmp++; if (npc !== EXC) begin n_bad++; $display("FAIL exc_npc: got %h want %h", npc, EXC); end
    tick();
    n_cmp++; if (pc !== EXC || ras_count !== 3'd1 || ras_miss_cnt !== 16'd0) begin n_bad++; $display("FAIL exc_ret: got pc %h cnt %0d miss %0d want 4180 1 0", pc, ras_count, ras_miss_cnt); end
    idle_inputs();
  endtask

  task automatic test_reset_midseq();
    do_reset();
    for (int i = 0; i < 3; i++) begin npc_sel = 3'd4; addr26 = 26'(i * 64); tick(); end
    npc_sel = 3'd6; rs_val = 32'hDEAD_BEEC;
    tick();
    npc_sel = 3'd5; rs_val = 32'h0000_5000;
    tick();
    n_cmp++; if (ras_count !== 3'd3 || ras_miss_cnt !== 16'd1) begin n_bad++; $display("FAIL mid_setup: got cnt %0d miss %0d want 3 1", ras_count, ras_miss_cnt); end
    reset = 1'b1; stall = 1'b1; npc_sel = 3'd4;
    tick();
    n_cmp++; if (pc !== RST_PC || ras_count !== 3'd0 || ras_miss_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_reset: got pc %h cnt %0d miss %0d want 3000 0 0", pc, ras_count, ras_miss_cnt); end
    n_cmp++; if (ras_valid !== 1'b0 || ras_top !== 32'h0) begin n_bad++; $display("FAIL mid_reset_top: got valid %b top %h want 0 0", ras_valid, ras_top); end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [31:0] exp_npc;
    logic [31:0] exp_top;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset        = ($urandom_range(63) == 0);
      stall        = ($urandom_range(5) == 0);
      exc_redirect = ($urandom_range(15) == 0);
      npc_sel      = 3'($urandom_range(7));
      br_taken     = 1'($urandom);
      imm16        = 16'($urandom);
      addr26       = 26'($urandom);
      if (m_ras.size() > 0 && $urandom_range(1) == 0) rs_val = m_ras[$];
      else if ($urandom_range(7) == 0)                 rs_val = 32'hFFFF_FFFC;
      else                                             rs_val = $urandom & 32'hFFFF_FFFC;
      #1;
      exp_npc = model_npc();
      n_cmp++; if (npc !== exp_npc) begin n_bad++; $display("FAIL rnd_npc[%0d]: got %h want %h", i, npc, exp_npc); end
      tick();
      exp_top = (m_ras.size() > 0) ? m_ras[$] : 32'h0;
      n_cmp++; if (pc !== m_pc) begin n_bad++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc, m_pc); end
      n_cmp++; if (link_addr !== m_pc + 32'd4) begin n_bad++; $display("FAIL rnd_link[%0d]: got %h want %h", i, link_addr, m_pc + 32'd4); end
      n_cmp++; if (ras_count !== 3'(m_ras.size()) || ras_valid !== (m_ras.size() > 0)) begin n_bad++; $display("FAIL rnd_count[%0d]: got %0d/%b want %0d", i, ras_count, ras_valid, m_ras.size()); end
      n_cmp++; if (ras_top !== exp_top) begin n_bad++; $display("FAIL rnd_top[%0d]: got %h want %h", i, ras_top, exp_top); end
      n_cmp++; if (ras_miss_cnt !== 16'(m_miss)) begin n_bad++; $display("FAIL rnd_miss[%0d]: got %0d want %0d", i, ras_miss_cnt, m_miss); end
    end
    idle_inputs();
  endtask

  initial begin
    m_pc = '0;
    m_miss = 0;
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_seq();
    test_branch();
    test_wrap();
    test_call_ret();
    test_ras_overflow();
    test_stall_exc();
    test_reset_midseq();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
